fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly around the 64-bit PC register. It holds the PC, presents it to the combinational instruction memory and computes the next PC (sequential or branch redirect). It latches {pc, instr} into an IF/ID register under a valid/ready handshake, with stall, flush and a retired-fetch counter. The decode/execute logic consumes its output.

Parameters:
N, 64, address/PC width in bits
RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned
CNT_W, 32, width of fetch_count

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
imem_addr  out  N  current PC to instruction memory, equal to pc_q (combinational read)
imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle
branch_taken  in  1  redirect request from downstream, sampled at posedge
branch_target  in  N  redirect address; bits [1:0] ignored (forced 0)
out_valid  out  1  IF/ID register holds a valid instruction
out_ready  in  1  consumer accepts the IF/ID contents this cycle
out_pc  out  N  PC of the instruction in IF/ID
out_instr  out  32  instruction word in IF/ID
fetch_count  out  CNT_W  number of completed out_valid & out_ready handshakes

Behaviour:
- Reset is asynchronous: pc_q=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fetch_count=0 immediately, independent of clk.
- imem_addr = pc_q at all times, combinationally, including during reset.
- adv = ~out_valid | out_ready. The IF/ID slot is empty or being drained.
- Each posedge with reset=0 applies the following priority:
  1. branch_taken=1: pc_q <= {branch_target[N-1:2],2'b00}; out_valid <= 0 (flush, regardless of out_ready); out_pc and out_instr hold their values. If out_valid & out_ready held in that cycle, the handshake still counts.
  2. else if adv: out_pc <= pc_q; out_instr <= imem_rdata; out_valid <= 1; pc_q <= pc_q + 4.
  3. else (stall: out_valid=1, out_ready=0): all registers hold; imem_addr stable.
- fetch_count increments by 1 on every posedge where out_valid & out_ready & ~reset. It wraps modulo 2^CNT_W.
- PC arithmetic is modulo 2^N: pc_q = {N{1}} with [1:0]=00, plus 4, gives 0. No exception and no flag.
- Latency: an instruction at PC p appears on out_* one posedge after pc_q=p, provided adv. Sustained throughput is 1 instruction/cycle with out_ready=1.
- After reset deasserts, the first posedge loads RESET_PC's instruction (out_valid=1) and pc_q becomes RESET_PC+4.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values asynchronously. Pending redirects are discarded.
- out_pc and out_instr are don't-care while out_valid=0. The bench must check them only when valid.
- No X may propagate from imem_rdata into out_valid or fetch_count.

Decomposition:
- Shared package fetch_pkg holds: INSTR_W=32, PC_INC=4, the alignment mask constant, and the packed struct if_id_t {pc, instr}.
- One natural sub-module is the existing parameterized reset flop (flopr #(N)), used for pc_q. Its reset value must be made parameterizable to RESET_PC, or it must be wrapped.
- The IF/ID register with enable/flush and the counter live inline in fetch_stage.

Test Plan:
- Reset then stream: RESET_PC=0, out_ready=1, imem returns addr^32'hCAFEBABE → handshakes deliver pc 0,4,8,C with matching instr; fetch_count=4 after 4 handshakes.
- Stall: out_ready=0 for 3 cycles while out_valid=1, pc_q=8 → out_pc=4 held, imem_addr=8 held, fetch_count unchanged. Raising out_ready resumes with pc 8 next.
- Branch flush: branch_taken=1 with target 64'h1000_0003 while out_valid=1, out_ready=0 → next cycle out_valid=0 and pc_q=64'h1000_0000. The following cycle out_pc=64'h1000_0000 and out_valid=1.
- Wrap-around: branch to 64'hFFFF_FFFF_FFFF_FFFC, out_ready=1 → out_pc=...FFFC, then out_pc=0.
- Asynchronous reset mid-operation: assert reset between clock edges at pc_q=64'h20, fetch_count=5 → pc_q=0, out_valid=0, fetch_count=0 before the next posedge.
- Counter wrap: CNT_W=4, run 17 accepted handshakes → fetch_count=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W        = 32;
  localparam int          PC_W           = 64;
  localparam logic [2:0]  PC_INC         = 3'd4;
  localparam logic [1:0]  ALIGN_LOW_MASK = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_flopr.sv
// Resettable register with a parameterizable asynchronous reset value.
module flopr #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// handshake register with flush and a retired-fetch counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [N-1:0]       imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [N-1:0]       branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [N-1:0]     w_pc;
  logic [N-1:0]     w_pc_next;
  logic [N-1:0]     w_target;
  logic             w_adv;
  logic             w_fire;
  logic             r_valid;
  if_id_t           r_if_id;
  logic [CNT_W-1:0] r_count;

  flopr #(
    .WIDTH     (N),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .d     (w_pc_next),
    .q     (w_pc)
  );

  assign w_target = branch_target & ~N'(ALIGN_LOW_MASK);
  assign w_adv    = ~r_valid | out_ready;
  assign w_fire   = r_valid & out_ready;

  // Next PC: redirect wins over sequential advance; a stall holds the PC.
  always_comb begin
    w_pc_next = w_pc;
    if (branch_taken) begin
      w_pc_next = w_target;
    end else if (w_adv) begin
      w_pc_next = w_pc + N'(PC_INC);
    end else begin
      w_pc_next = w_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_if_id <= '0;
    end else if (branch_taken) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid       <= 1'b1;
      r_if_id.pc    <= PC_W'(w_pc);
      r_if_id.instr <= imem_rdata;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Counts consumer handshakes, including one coinciding with a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_fire) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign imem_addr   = w_pc;
  assign out_valid   = r_valid;
  assign out_pc      = r_if_id.pc[N-1:0];
  assign out_instr   = r_if_id.instr;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage, with a second narrow-counter
// instance for the counter wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] fetch_count;

  logic        reset4;
  logic [63:0] imem_addr4;
  logic [31:0] imem_rdata4;
  logic        out_valid4;
  logic [63:0] out_pc4;
  logic [31:0] out_instr4;
  logic [3:0]  fetch_count4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr[31:0] ^ 32'hCAFE_BABE;
  assign imem_rdata4 = imem_addr4[31:0] ^ 32'hCAFE_BABE;

  fetch_stage #(.N(64), .RESET_PC(64'h0), .CNT_W(32)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fetch_count   (fetch_count)
  );

  fetch_stage #(.N(64), .RESET_PC(64'h0), .CNT_W(4)) u_dut4 (
    .clk           (clk),
    .reset         (reset4),
    .imem_addr     (imem_addr4),
    .imem_rdata    (imem_rdata4),
    .branch_taken  (1'b0),
    .branch_target (64'h0),
    .out_valid     (out_valid4),
    .out_ready     (1'b1),
    .out_pc        (out_pc4),
    .out_instr     (out_instr4),
    .fetch_count   (fetch_count4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    reset4        = 1'b1;
    out_ready     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    #1;
    check_eq("rst_addr",  imem_addr,   64'h0);
    check_eq("rst_valid", out_valid,   64'h0);
    check_eq("rst_pc",    out_pc,      64'h0);
    check_eq("rst_instr", out_instr,   64'h0);
    check_eq("rst_count", fetch_count, 64'h0);

    // Streaming with the consumer always ready.
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq($sformatf("str_valid%0d", k), out_valid, 64'h1);
      check_eq($sformatf("str_pc%0d", k), out_pc, 64'(4 * (k - 1)));
      check_eq($sformatf("str_instr%0d", k), out_instr,
               64'(32'(4 * (k - 1)) ^ 32'hCAFE_BABE));
      check_eq($sformatf("str_cnt%0d", k), fetch_count, 64'(k - 1));
    end
    check_eq("str_addr", imem_addr, 64'h14);

    // Stall with pc_q=8 and IF/ID holding pc 4.
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    check_eq("pre_stall_pc",  out_pc,      64'h4);
    check_eq("pre_stall_cnt", fetch_count, 64'h1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_valid", out_valid,   64'h1);
      check_eq("stall_pc",    out_pc,      64'h4);
      check_eq("stall_addr",  imem_addr,   64'h8);
      check_eq("stall_cnt",   fetch_count, 64'h1);
    end
    out_ready = 1'b1;
    step();
    check_eq("resume_pc",   out_pc,      64'h8);
    check_eq("resume_cnt",  fetch_count, 64'h2);
    check_eq("resume_addr", imem_addr,   64'hC);

    // Flush while stalled: target low bits are dropped.
    out_ready     = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h1000_0003;
    step();
    check_eq("flush_valid", out_valid,   64'h0);
    check_eq("flush_addr",  imem_addr,   64'h1000_0000);
    check_eq("flush_cnt",   fetch_count, 64'h2);
    branch_taken = 1'b0;
    step();
    check_eq("redir_valid", out_valid, 64'h1);
    check_eq("redir_pc",    out_pc,    64'h1000_0000);
    check_eq("redir_instr", out_instr, 64'hDAFE_BABE);
    check_eq("redir_addr",  imem_addr, 64'h1000_0004);

    // Branch coinciding with a handshake still counts it; then PC wraps.
    out_ready     = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check_eq("brhs_valid", out_valid,   64'h0);
    check_eq("brhs_cnt",   fetch_count, 64'h3);
    check_eq("brhs_addr",  imem_addr,   64'hFFFF_FFFF_FFFF_FFFC);
    branch_taken = 1'b0;
    step();
    check_eq("wrap_pc",    out_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_instr", out_instr, 64'h3501_4542);
    check_eq("wrap_addr",  imem_addr, 64'h0);
    step();
    check_eq("wrap_pc0",  out_pc,      64'h0);
    check_eq("wrap_cnt",  fetch_count, 64'h4);

    // Async reset between edges with pc_q=0x20, count=5, redirect pending.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check_eq("pre_ar_cnt",  fetch_count, 64'h5);
    out_ready     = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h20;
    step();
    check_eq("pre_ar_addr", imem_addr,   64'h20);
    check_eq("pre_ar_cnt2", fetch_count, 64'h5);
    branch_target = 64'h400;
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_addr",  imem_addr,   64'h0);
    check_eq("ar_valid", out_valid,   64'h0);
    check_eq("ar_cnt",   fetch_count, 64'h0);
    @(negedge clk);
    reset        = 1'b0;
    branch_taken = 1'b0;
    out_ready    = 1'b1;
    step();
    check_eq("post_ar_valid", out_valid, 64'h1);
    check_eq("post_ar_pc",    out_pc,    64'h0);
    check_eq("post_ar_addr",  imem_addr, 64'h4);

    // Narrow counter: 16 handshakes wrap to 0, the 17th gives 1.
    reset4 = 1'b0;
    for (int k = 0; k < 17; k++) step();
    check_eq("cnt4_wrap0", fetch_count4, 64'h0);
    step();
    check_eq("cnt4_wrap1", fetch_count4, 64'h1);
    check_eq("cnt4_pc",    out_pc4,      64'h44);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
